// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time to instruction memory and
// hands the registered word to the decoder. Optional ebreak halt: YSYX_23060332_IFU_EBREAK_HALT_EN.
module ysyx_23060332_ifu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h8000_0000)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              imem_rsp_ready,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              halted
);

`ifdef YSYX_23060332_IFU_EBREAK_HALT_EN
  localparam logic [DATA_W-1:0] EBREAK = DATA_W'(32'h0010_0073);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
`endif

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic              kill, kill_nxt;
  logic [DATA_W-1:0] inst_q, inst_nxt;
  logic [ADDR_W-1:0] inst_addr_q, inst_addr_nxt;
  logic              halted_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      kill        <= 1'b0;
      inst_q      <= '0;
      inst_addr_q <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      kill        <= kill_nxt;
      inst_q      <= inst_nxt;
      inst_addr_q <= inst_addr_nxt;
    end
  end

`ifdef YSYX_23060332_IFU_EBREAK_HALT_EN
  logic halted_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halted_q <= 1'b0;
    else        halted_q <= halted_nxt;
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  // jump_en wins over every other event; a fetch that is in flight when it arrives is
  // marked with kill so its response is swallowed instead of reaching the decoder.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    kill_nxt      = kill;
    inst_nxt      = inst_q;
    inst_addr_nxt = inst_addr_q;
`ifdef YSYX_23060332_IFU_EBREAK_HALT_EN
    halted_nxt    = halted_q;
`else
    halted_nxt    = 1'b0;
`endif
    case (state)
      S_REQ: begin
        if (jump_en) pc_nxt = jump_addr;
        if (imem_req_ready) begin
          state_nxt = S_WAIT;
          kill_nxt  = jump_en;
        end
      end
      S_WAIT: begin
        if (jump_en) begin
          pc_nxt   = jump_addr;
          kill_nxt = 1'b1;
        end
        if (imem_rsp_valid) begin
          if (jump_en || kill) begin
            kill_nxt  = 1'b0;
            state_nxt = S_REQ;
          end else begin
            inst_nxt      = imem_rsp_data;
            inst_addr_nxt = pc;
            state_nxt     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (jump_en) begin
          pc_nxt    = jump_addr;
          state_nxt = S_REQ;
        end else if (inst_ready) begin
`ifdef YSYX_23060332_IFU_EBREAK_HALT_EN
          if (inst_q == EBREAK) begin
            halted_nxt = 1'b1;
            state_nxt  = S_HALT;
          end else begin
            pc_nxt    = pc + ADDR_W'(4);
            state_nxt = S_REQ;
          end
`else
          pc_nxt    = pc + ADDR_W'(4);
          state_nxt = S_REQ;
`endif
        end
      end
`ifdef YSYX_23060332_IFU_EBREAK_HALT_EN
      S_HALT: state_nxt = S_HALT;
`endif
      default: state_nxt = S_REQ;
    endcase
  end

  // Handshake outputs are forced low while reset is asserted, not just after the first edge.
  assign imem_req_valid = rst_n && (state == S_REQ);
  assign imem_rsp_ready = rst_n && (state == S_WAIT);
  assign inst_valid     = rst_n && (state == S_HOLD);
  assign imem_addr      = pc;
  assign inst_o         = inst_q;
  assign inst_addr      = inst_addr_q;

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Directed bench for ysyx_23060332_ifu with a one-deep memory model and an expected-instruction queue.
module tb_ysyx_23060332_ifu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid, imem_rsp_ready;
  logic [31:0] imem_rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_o, inst_addr;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        halted;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sbq[$];
  int          tests = 0;
  int          fails = 0;
  logic        pending;
  int          countdown;
  int          rsp_delay;
  logic [31:0] paddr;

  ysyx_23060332_ifu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .imem_rsp_ready(imem_rsp_ready),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_o        (inst_o),
    .inst_addr     (inst_addr),
    .jump_en       (jump_en),
    .jump_addr     (jump_addr),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0010_0093;
    if (a == 32'h8000_0200) return 32'h0010_0073;
    return {a[31:2], 2'b11} ^ 32'h5a5a_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: note handshakes at the negedge, pop/compare consumed words, then let the memory respond.
  task automatic cycle();
    logic        acc, rhs;
    logic [31:0] aaddr;
    exp_t        e;
    acc   = imem_req_valid & imem_req_ready;
    aaddr = imem_addr;
    rhs   = imem_rsp_valid & imem_rsp_ready;
    if (inst_valid && inst_ready && !jump_en) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $error("[TB] FAIL unexpected_inst observed addr=%h expected none", inst_addr);
      end else begin
        e = sbq.pop_front();
        check("sb_inst_o", inst_o, e.data);
        check("sb_inst_addr", inst_addr, e.addr);
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (rhs) imem_rsp_valid = 1'b0;
    if (acc) begin
      pending   = 1'b1;
      paddr     = aaddr;
      countdown = rsp_delay;
    end
    if (pending && !imem_rsp_valid) begin
      if (countdown == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memf(paddr);
        pending        = 1'b0;
      end else begin
        countdown--;
      end
    end
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!inst_valid && n < budget) begin
      cycle();
      n++;
    end
    check("inst_valid_timeout", {31'd0, inst_valid}, 32'd1);
  endtask

  task automatic fetch_one(input logic [31:0] a);
    int n;
    sbq.push_back({a, memf(a)});
    wait_valid(20, n);
    inst_ready = 1'b1;
    cycle();
    inst_ready = 1'b0;
  endtask

  initial begin
    int  n;
    logic seen;
    logic [31:0] held_o, held_a;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    inst_ready     = 1'b0;
    jump_en        = 1'b0;
    jump_addr      = '0;
    pending        = 1'b0;
    countdown      = 0;
    rsp_delay      = 0;
    paddr          = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_rsp_ready", {31'd0, imem_rsp_ready}, 32'd0);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst_o", inst_o, 32'd0);
    check("rst_inst_addr", inst_addr, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);

    rst_n = 1'b1;
    #1;
    check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("first_addr", imem_addr, 32'h8000_0000);

    sbq.push_back({32'h8000_0000, 32'h0010_0093});
    wait_valid(10, n);
    check("first_latency", n, 32'd2);
    check("first_inst_o", inst_o, 32'h0010_0093);
    check("first_inst_addr", inst_addr, 32'h8000_0000);

    held_o = inst_o;
    held_a = inst_addr;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("hold_valid", {31'd0, inst_valid}, 32'd1);
      check("hold_inst_o", inst_o, held_o);
      check("hold_inst_addr", inst_addr, held_a);
      check("hold_no_req", {31'd0, imem_req_valid}, 32'd0);
    end
    inst_ready = 1'b1;
    cycle();
    inst_ready = 1'b0;
    check("next_addr", imem_addr, 32'h8000_0004);
    check("next_req_valid", {31'd0, imem_req_valid}, 32'd1);

    rsp_delay = 2;
    cycle();
    check("wait_rsp_ready", {31'd0, imem_rsp_ready}, 32'd1);
    jump_en   = 1'b1;
    jump_addr = 32'h8000_0100;
    cycle();
    jump_en = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!imem_req_valid && n < 20) begin
      seen |= inst_valid;
      cycle();
      n++;
    end
    seen |= inst_valid;
    check("killed_never_valid", {31'd0, seen}, 32'd0);
    check("jump_wait_addr", imem_addr, 32'h8000_0100);
    check("jump_wait_req", {31'd0, imem_req_valid}, 32'd1);
    rsp_delay = 0;
    fetch_one(32'h8000_0100);
    check("after_jump_addr", imem_addr, 32'h8000_0104);

    wait_valid(20, n);
    check("hold_drop_addr", inst_addr, 32'h8000_0104);
    inst_ready = 1'b1;
    jump_en    = 1'b1;
    jump_addr  = 32'h8000_0300;
    cycle();
    jump_en    = 1'b0;
    inst_ready = 1'b0;
    check("hold_jump_addr", imem_addr, 32'h8000_0300);
    check("hold_jump_req", {31'd0, imem_req_valid}, 32'd1);

    imem_req_ready = 1'b0;
    jump_en   = 1'b1;
    jump_addr = 32'h8000_0400;
    cycle();
    check("req_jump_addr", imem_addr, 32'h8000_0400);
    jump_addr = 32'hffff_fffc;
    cycle();
    jump_en = 1'b0;
    check("req_jump2_addr", imem_addr, 32'hffff_fffc);
    imem_req_ready = 1'b1;
    fetch_one(32'hffff_fffc);
    check("wrap_addr", imem_addr, 32'h0000_0000);

    rsp_delay = 3;
    cycle();
    check("pre_rst_wait", {31'd0, imem_rsp_ready}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("midrst_rsp_ready", {31'd0, imem_rsp_ready}, 32'd0);
    check("midrst_inst_valid", {31'd0, inst_valid}, 32'd0);
    pending        = 1'b0;
    imem_rsp_valid = 1'b0;
    rsp_delay      = 0;
    @(negedge clk);
    cycle();
    rst_n = 1'b1;
    #1;
    check("postrst_addr", imem_addr, 32'h8000_0000);
    check("postrst_req", {31'd0, imem_req_valid}, 32'd1);
    fetch_one(32'h8000_0000);

    jump_en   = 1'b1;
    jump_addr = 32'h8000_0200;
    cycle();
    jump_en = 1'b0;
    sbq.push_back({32'h8000_0200, 32'h0010_0073});
    wait_valid(20, n);
    check("ebreak_inst_o", inst_o, 32'h0010_0073);
    inst_ready = 1'b1;
    cycle();
    inst_ready = 1'b0;
`ifdef YSYX_23060332_IFU_EBREAK_HALT_EN
    check("halted_set", {31'd0, halted}, 32'd1);
    jump_en   = 1'b1;
    jump_addr = 32'h8000_0000;
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("halt_no_req", {31'd0, imem_req_valid}, 32'd0);
      check("halt_no_inst", {31'd0, inst_valid}, 32'd0);
    end
    jump_en = 1'b0;
    check("halted_stays", {31'd0, halted}, 32'd1);
`else
    check("halted_tied", {31'd0, halted}, 32'd0);
    check("ebreak_next_addr", imem_addr, 32'h8000_0204);
    check("ebreak_next_req", {31'd0, imem_req_valid}, 32'd1);
`endif

    check("sb_drained", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
